// File: rtl/overcooked_pkg.sv
// overcooked_pkg: kitchen object codes, grid geometry and shared grid types
package overcooked_pkg;
  localparam int GRID_W = 13;
  localparam int GRID_H = 8;
  localparam logic [3:0] G_EMPTY         = 4'd0;
  localparam logic [3:0] G_ONION_WHOLE   = 4'd1;
  localparam logic [3:0] G_ONION_CHOPPED = 4'd2;
  localparam logic [3:0] G_BOWL_EMPTY    = 4'd3;
  localparam logic [3:0] G_BOWL_FULL     = 4'd4;
  localparam logic [3:0] G_POT_EMPTY     = 4'd5;
  localparam logic [3:0] G_POT_COOKING   = 4'd6;
  localparam logic [3:0] G_POT_DONE      = 4'd7;
  localparam logic [3:0] G_POT_BURNT     = 4'd8;
  localparam logic [3:0] G_FIRE          = 4'd9;
  localparam logic [3:0] G_EXTINGUISHER  = 4'd10;
  typedef logic [GRID_H-1:0][GRID_W-1:0][3:0] grid_t;
  typedef struct packed {
    logic [3:0] x;
    logic [2:0] y;
    logic [3:0] expected;
    logic [3:0] value;
  } grid_req_t;
  function automatic grid_t init_grid();
    grid_t g;
    g = '0;
    g[2][0] = G_ONION_WHOLE;
    g[3][0] = G_ONION_WHOLE;
    g[6][12] = G_BOWL_EMPTY;
    for (int x = 8; x <= 11; x++) g[0][x] = G_POT_EMPTY;
    g[0][7] = G_EXTINGUISHER;
    return g;
  endfunction
endpackage

// File: rtl/grid_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts one past the pointer and wraps
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_elig,
  input  logic [W-1:0] i_ptr,
  output logic         o_grant_valid,
  output logic [W-1:0] o_grant_idx
);
  // walk candidates furthest-first so the nearest eligible one after the pointer wins
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (i_elig[(int'(i_ptr) + k) % N]) begin
        o_grant_valid = 1'b1;
        o_grant_idx = W'((int'(i_ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/grid_write_arbiter.sv
// grid_write_arbiter: owns object_grid, serialises player CAS writes and serving-window clears (optional GRID_ARB_WAIT_STATS_EN adds wait counters and max_wait)
module grid_write_arbiter
  import overcooked_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                                vsync,
  input  logic                                reset_n,
  input  logic [1:0]                          num_players,
  input  logic [1:0]                          sys_clear,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][3:0]             req_x,
  input  logic [NUM_REQ-1:0][2:0]             req_y,
  input  logic [NUM_REQ-1:0][3:0]             req_expect,
  input  logic [NUM_REQ-1:0][3:0]             req_value,
  output logic [NUM_REQ-1:0]                  req_ack,
  output logic [NUM_REQ-1:0]                  req_ok,
  output logic [1:0]                          last_grant,
`ifdef GRID_ARB_WAIT_STATS_EN
  output logic [7:0]                          max_wait,
`endif
  output logic [GRID_H-1:0][GRID_W-1:0][3:0] object_grid
);
  grid_t r_grid;
  logic [NUM_REQ-1:0] r_ack, r_ok, w_active, w_elig;
  logic [1:0] r_last, w_gi;
  logic [2:0] w_cnt;
  logic w_gv, w_hit_clear, w_ok;
  grid_req_t w_req;
  assign w_cnt = num_players == 2'd0 ? 3'd1 : {1'b0, num_players};
  // ports at or above the active player count never compete
  always_comb begin
    w_active = '0;
    for (int i = 0; i < NUM_REQ; i++) w_active[i] = i < int'(w_cnt);
  end
  assign w_elig = req_valid & w_active & ~r_ack;
  rr_pick #(.N(NUM_REQ), .W(2)) u_pick (
    .i_elig(w_elig),
    .i_ptr(r_last),
    .o_grant_valid(w_gv),
    .o_grant_idx(w_gi)
  );
  assign w_req = '{x: req_x[w_gi], y: req_y[w_gi], expected: req_expect[w_gi], value: req_value[w_gi]};
  assign w_hit_clear = w_req.x == 4'd12 && ((sys_clear[0] && w_req.y == 3'd4) || (sys_clear[1] && w_req.y == 3'd5));
  assign w_ok = w_gv && w_req.x < 4'(GRID_W) && {1'b0, w_req.y} < 4'(GRID_H) && !w_hit_clear && r_grid[w_req.y][w_req.x] == w_req.expected;
  // one grant per frame; the serving-window clear lands after the player write so it always wins
  always_ff @(negedge vsync) begin
    if (!reset_n) begin
      r_grid <= init_grid();
      r_ack <= '0;
      r_ok <= '0;
      r_last <= '0;
    end else begin
      r_ack <= '0;
      r_ok <= '0;
      if (w_gv) begin
        r_ack[w_gi] <= 1'b1;
        r_ok[w_gi] <= w_ok;
        r_last <= w_gi;
      end
      if (w_ok) r_grid[w_req.y][w_req.x] <= w_req.value;
      if (sys_clear[0]) r_grid[4][12] <= G_EMPTY;
      if (sys_clear[1]) r_grid[5][12] <= G_EMPTY;
    end
  end
  assign req_ack = r_ack;
  assign req_ok = r_ok;
  assign last_grant = r_last;
  assign object_grid = r_grid;
`ifdef GRID_ARB_WAIT_STATS_EN
  logic [NUM_REQ-1:0][7:0] r_wait;
  logic [7:0] r_max, w_max;
  // largest outstanding wait across all ports
  always_comb begin
    w_max = '0;
    for (int i = 0; i < NUM_REQ; i++) w_max = r_wait[i] > w_max ? r_wait[i] : w_max;
  end
  // saturating per-port wait counters, zeroed when the port is granted
  always_ff @(negedge vsync) begin
    if (!reset_n) begin
      r_wait <= '0;
      r_max <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        r_wait[i] <= (w_gv && w_gi == 2'(i)) ? 8'd0 : (w_elig[i] && r_wait[i] != 8'hff) ? r_wait[i] + 8'd1 : r_wait[i];
      r_max <= w_max;
    end
  end
  assign max_wait = r_max;
`endif
endmodule

// File: tb/tb_grid_write_arbiter.sv
// tb_grid_write_arbiter: directed and randomized checks against a frame-level reference model
module tb_grid_write_arbiter;
  logic vsync = 1'b1;
  logic reset_n = 1'b0;
  logic [1:0] num_players = '0;
  logic [1:0] sys_clear = '0;
  logic [3:0] req_valid = '0;
  logic [3:0][3:0] req_x = '0;
  logic [3:0][2:0] req_y = '0;
  logic [3:0][3:0] req_expect = '0;
  logic [3:0][3:0] req_value = '0;
  logic [3:0] req_ack, req_ok;
  logic [1:0] last_grant;
  logic [7:0][12:0][3:0] object_grid;
`ifdef GRID_ARB_WAIT_STATS_EN
  logic [7:0] max_wait;
`endif
  grid_write_arbiter dut (
    .vsync(vsync),
    .reset_n(reset_n),
    .num_players(num_players),
    .sys_clear(sys_clear),
    .req_valid(req_valid),
    .req_x(req_x),
    .req_y(req_y),
    .req_expect(req_expect),
    .req_value(req_value),
    .req_ack(req_ack),
    .req_ok(req_ok),
    .last_grant(last_grant),
`ifdef GRID_ARB_WAIT_STATS_EN
    .max_wait(max_wait),
`endif
    .object_grid(object_grid)
  );
  always #5 vsync = ~vsync;
  int mg[8][13];
  logic [3:0] m_ack, m_ok;
  int m_last;
  int n_vec = 0;
  int n_err = 0;
  task automatic check(input string tag, input logic [415:0] got, input logic [415:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic void m_init();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 13; x++) mg[y][x] = 0;
    mg[2][0] = 1;
    mg[3][0] = 1;
    mg[6][12] = 3;
    for (int x = 8; x <= 11; x++) mg[0][x] = 5;
    mg[0][7] = 10;
    m_ack = '0;
    m_ok = '0;
    m_last = 0;
  endfunction
  function automatic logic [415:0] m_grid();
    logic [415:0] r;
    r = '0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 13; x++) r[(y*13+x)*4 +: 4] = 4'(mg[y][x]);
    return r;
  endfunction
  function automatic void m_step();
    int cnt, g, x, y;
    bit ok;
    if (!reset_n) begin
      m_init();
      return;
    end
    cnt = num_players == 0 ? 1 : int'(num_players);
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (m_last + k) % 4;
      if (g < 0 && req_valid[i] && i < cnt && !m_ack[i]) g = i;
    end
    m_ack = '0;
    m_ok = '0;
    if (g >= 0) begin
      x = int'(req_x[g]);
      y = int'(req_y[g]);
      ok = x < 13 && y < 8 && !(x == 12 && ((sys_clear[0] && y == 4) || (sys_clear[1] && y == 5)));
      if (ok) ok = mg[y][x] == int'(req_expect[g]);
      m_ack[g] = 1'b1;
      m_ok[g] = ok;
      m_last = g;
      if (ok) mg[y][x] = int'(req_value[g]);
    end
    if (sys_clear[0]) mg[4][12] = 0;
    if (sys_clear[1]) mg[5][12] = 0;
  endfunction
  task automatic tick();
    logic [1:0] lg;
    m_step();
    lg = 2'(m_last);
    @(negedge vsync);
    @(posedge vsync);
    #1;
    check("ack", req_ack, m_ack);
    check("ok", req_ok, m_ok);
    check("last_grant", last_grant, lg);
    check("grid", object_grid, m_grid());
  endtask
  task automatic req(input int i, input int x, input int y, input int e, input int v);
    req_valid[i] = 1'b1;
    req_x[i] = 4'(x);
    req_y[i] = 3'(y);
    req_expect[i] = 4'(e);
    req_value[i] = 4'(v);
  endtask
  initial begin
    tick();
    tick();
    reset_n = 1'b1;
    check("rst_0_8", object_grid[0][8], 4'd5);
    check("rst_2_0", object_grid[2][0], 4'd1);
    check("rst_6_12", object_grid[6][12], 4'd3);
    check("rst_0_7", object_grid[0][7], 4'd10);
    check("rst_ack", req_ack, 4'd0);
    check("rst_last", last_grant, 2'd0);
    num_players = 2'd2;
    req(0, 0, 2, 1, 0);
    req(1, 0, 2, 1, 0);
    tick();
    check("cas_race_ack1", req_ack, 4'b0010);
    check("cas_race_ok1", req_ok, 4'b0010);
    check("cas_race_cell", object_grid[2][0], 4'd0);
    req_valid[1] = 1'b0;
    tick();
    check("cas_race_ack0", req_ack, 4'b0001);
    check("cas_race_ok0", req_ok, 4'b0000);
    check("cas_race_cell2", object_grid[2][0], 4'd0);
    req_valid = '0;
    tick();
    num_players = 2'd0;
    for (int i = 0; i < 4; i++) req(i, 14, 1, 0, 0);
    for (int n = 0; n < 8; n++) begin
      tick();
      check("np0_only_p0", req_ack[3:1], 3'd0);
    end
    num_players = 2'd3;
    for (int n = 0; n < 9; n++) begin
      tick();
      check("np3_no_p3", req_ack[3], 1'b0);
    end
    req_valid = '0;
    tick();
    req(0, 12, 4, 0, 4);
    tick();
    check("clr_setup", object_grid[4][12], 4'd4);
    req_valid[0] = 1'b0;
    req(2, 12, 4, 4, 0);
    sys_clear = 2'b11;
    tick();
    check("clr_ack", req_ack, 4'b0100);
    check("clr_ok", req_ok, 4'b0000);
    check("clr_4_12", object_grid[4][12], 4'd0);
    check("clr_5_12", object_grid[5][12], 4'd0);
    sys_clear = '0;
    req_valid = '0;
    tick();
    req(0, 13, 0, 0, 1);
    tick();
    check("xrange_ack", req_ack, 4'b0001);
    check("xrange_ok", req_ok, 4'b0000);
    tick();
    check("hold_no_reack", req_ack, 4'b0000);
    tick();
    check("hold_reack", req_ack, 4'b0001);
    req_valid = '0;
    tick();
    for (int n = 0; n < 500; n++) begin
      reset_n = ($urandom % 50) != 0;
      if ($urandom % 20 == 0) num_players = 2'($urandom);
      sys_clear = ($urandom % 8 == 0) ? 2'($urandom) : 2'b00;
      for (int i = 0; i < 4; i++) begin
        bit fresh;
        fresh = (req_valid[i] && m_ack[i]) ? ($urandom % 2 == 0) : (!req_valid[i] && $urandom % 3 == 0);
        if (req_valid[i] && m_ack[i] && !fresh) req_valid[i] = 1'b0;
        else if (fresh) begin
          int x, y;
          x = int'($urandom % 15);
          y = int'($urandom % 8);
          req(i, x, y, (x < 13 && $urandom % 4 != 0) ? mg[y][x] : int'($urandom % 11), int'($urandom % 11));
        end
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
